// File: rtl/pdm_audio_dac_if.sv
// Sample-transfer bus between the phi2/dot_clk sample source and the PDM DAC.
// The source drives samples, the toggle and the volume; the DAC returns the capture strobe.
interface pdm_audio_dac_if #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2,
  parameter int VOL_BITS = 4
);
  logic [CHANNELS*WIDTH-1:0] sample_i;
  logic                      sample_tgl_i;
  logic [VOL_BITS-1:0]       vol_i;
  logic                      sample_stb_o;

  modport master (
    output sample_i,
    output sample_tgl_i,
    output vol_i,
    input  sample_stb_o
  );

  modport slave (
    input  sample_i,
    input  sample_tgl_i,
    input  vol_i,
    output sample_stb_o
  );
endinterface

// File: rtl/pdm_audio_dac.sv
// Multi-channel first-order sigma-delta PDM DAC with toggle-handshake sample capture,
// per-block volume scaling and a click-free fade ramp driving the amplifier shutdown pin.
module pdm_audio_dac #(
  parameter int WIDTH      = 12,
  parameter int CHANNELS   = 2,
  parameter int VOL_BITS   = 4,
  parameter int RAMP_SHIFT = 10
) (
  input  logic                color_clk,
  input  logic                reset,
  pdm_audio_dac_if.slave      bus,
  input  logic                enable_i,
  output logic [CHANNELS-1:0] pdm_o,
  output logic                sd_o,
  output logic [1:0]          state_o
);

  localparam int VOL_PROD_W  = WIDTH + VOL_BITS + 1;
  localparam int RAMP_PROD_W = WIDTH + 9;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] f_vol_scale(input logic [WIDTH-1:0]    smp,
                                                   input logic [VOL_BITS-1:0] vol);
    logic [VOL_BITS:0]     gain;
    logic [VOL_PROD_W-1:0] prod;
    gain = (VOL_BITS+1)'(vol) + (VOL_BITS+1)'(1);
    prod = VOL_PROD_W'(smp) * VOL_PROD_W'(gain);
    return WIDTH'(prod >> VOL_BITS);
  endfunction

  // Ramp is 0..256 so full scale (256) passes the sample through unchanged.
  function automatic logic [WIDTH-1:0] f_ramp_scale(input logic [WIDTH-1:0] smp,
                                                    input logic [8:0]       ramp);
    logic [RAMP_PROD_W-1:0] prod;
    prod = RAMP_PROD_W'(smp) * RAMP_PROD_W'(ramp);
    return WIDTH'(prod >> 8);
  endfunction

  logic                  r_tgl_s1, r_tgl_s2, r_tgl_s3;
  logic                  w_tgl_edge;
  logic                  r_vld_p0;
  logic [WIDTH-1:0]      r_hold_p0   [CHANNELS];
  logic [WIDTH-1:0]      r_scaled_p1 [CHANNELS];
  logic [WIDTH-1:0]      r_eff_p2    [CHANNELS];
  logic [WIDTH-1:0]      r_acc_p3    [CHANNELS];
  logic [CHANNELS-1:0]   r_pdm_p3;

  state_t                r_state, w_state_nxt;
  logic [8:0]            r_ramp, w_ramp_nxt;
  logic [RAMP_SHIFT-1:0] r_presc;
  logic                  w_presc_clr;
  logic                  w_wrap;

  // The toggle crosses clock domains; s1 may go metastable, s2/s3 are clean.
  always_ff @(posedge color_clk) begin
    if (reset) begin
      r_tgl_s1 <= 1'b0;
      r_tgl_s2 <= 1'b0;
      r_tgl_s3 <= 1'b0;
    end else begin
      r_tgl_s1 <= bus.sample_tgl_i;
      r_tgl_s2 <= r_tgl_s1;
      r_tgl_s3 <= r_tgl_s2;
    end
  end

  assign w_tgl_edge = r_tgl_s2 ^ r_tgl_s3;

  // p0: capture the sample set into the hold registers
  always_ff @(posedge color_clk) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) r_hold_p0[c] <= '0;
    end else begin
      r_vld_p0 <= w_tgl_edge;
      if (w_tgl_edge) begin
        for (int c = 0; c < CHANNELS; c++) r_hold_p0[c] <= bus.sample_i[c*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.sample_stb_o = r_vld_p0;

  // p1: volume scaling; p2: fade ramp scaling
  always_ff @(posedge color_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      r_scaled_p1[c] <= f_vol_scale(r_hold_p0[c], bus.vol_i);
      r_eff_p2[c]    <= f_ramp_scale(r_scaled_p1[c], r_ramp);
    end
  end

  // p3: first-order modulator, the accumulator carry is the PDM bit
  always_ff @(posedge color_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset || (r_state == ST_OFF)) begin
        r_acc_p3[c] <= '0;
        r_pdm_p3[c] <= 1'b0;
      end else begin
        {r_pdm_p3[c], r_acc_p3[c]} <= {1'b0, r_acc_p3[c]} + {1'b0, r_eff_p2[c]};
      end
    end
  end

  assign w_wrap = &r_presc;

  always_ff @(posedge color_clk) begin
    if (reset) begin
      r_state <= ST_OFF;
      r_ramp  <= '0;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ramp  <= w_ramp_nxt;
      r_presc <= w_presc_clr ? '0 : r_presc + 1'b1;
    end
  end

  // Direction changes take priority over a ramp step, so a reversal never skips a value.
  always_comb begin
    w_state_nxt = r_state;
    w_ramp_nxt  = r_ramp;
    w_presc_clr = 1'b0;
    case (r_state)
      ST_OFF: begin
        w_ramp_nxt = '0;
        if (enable_i) begin
          w_state_nxt = ST_RAMP_UP;
          w_presc_clr = 1'b1;
        end
      end
      ST_RAMP_UP: begin
        if (!enable_i) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else if (r_ramp == 9'd256) begin
          w_state_nxt = ST_RUN;
        end else if (w_wrap) begin
          w_ramp_nxt = r_ramp + 9'd1;
          if (r_ramp == 9'd255) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_ramp_nxt = 9'd256;
        if (!enable_i) w_state_nxt = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (enable_i) begin
          w_state_nxt = ST_RAMP_UP;
        end else if (r_ramp == 9'd0) begin
          w_state_nxt = ST_OFF;
        end else if (w_wrap) begin
          w_ramp_nxt = r_ramp - 9'd1;
          if (r_ramp == 9'd1) w_state_nxt = ST_OFF;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_ramp_nxt  = '0;
      end
    endcase
  end

  assign pdm_o   = r_pdm_p3;
  assign sd_o    = (r_state != ST_OFF);
  assign state_o = r_state;

endmodule

// File: tb/tb_pdm_audio_dac.sv
// Self-checking bench for pdm_audio_dac: ramp timing, PDM ones density against a
// gain model, toggle capture, ramp reversal and mid-ramp reset.
module tb_pdm_audio_dac;

  localparam int W  = 12;
  localparam int CH = 2;
  localparam int VB = 4;
  localparam int RS = 2;
  localparam int STEP_CYC = 1 << RS;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CH-1:0] pdm;
  logic          sd;
  logic [1:0]    st;

  pdm_audio_dac_if #(.WIDTH(W), .CHANNELS(CH), .VOL_BITS(VB)) bus ();

  pdm_audio_dac #(.WIDTH(W), .CHANNELS(CH), .VOL_BITS(VB), .RAMP_SHIFT(RS)) dut (
    .color_clk (clk),
    .reset     (rst),
    .bus       (bus),
    .enable_i  (en),
    .pdm_o     (pdm),
    .sd_o      (sd),
    .state_o   (st)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stb_cnt = 0;

  always @(negedge clk) if (bus.sample_stb_o) stb_cnt <= stb_cnt + 1;

  typedef struct {
    int s0;
    int s1;
    int vol;
    int e0;
    int e1;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Gain model: output level is the sample times (vol+1)/16, rounded down.
  function automatic int ref_scale(input int s, input int v);
    return (s * (v + 1)) / (1 << VB);
  endfunction

  task automatic send(input int s0, input int s1, input int vol);
    @(negedge clk);
    bus.sample_i     = {W'(s1), W'(s0)};
    bus.vol_i        = VB'(vol);
    bus.sample_tgl_i = ~bus.sample_tgl_i;
    repeat (10) @(negedge clk);
  endtask

  task automatic measure(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    repeat (1 << W) begin
      @(negedge clk);
      n0 += int'(pdm[0]);
      n1 += int'(pdm[1]);
    end
  endtask

  task automatic wait_ramp(input int val, input int budget, input string name);
    int t = 0;
    while (int'(dut.r_ramp) != val && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, int'(dut.r_ramp), val);
  endtask

  initial begin
    int n, n0, n1, viol, prev, prev_sd, s0, s1, v;

    tbl[0] = '{s0: 2048, s1: 2048, vol: 15, e0: 2048, e1: 2048};
    tbl[1] = '{s0: 0,    s1: 4095, vol: 15, e0: 0,    e1: 4095};
    tbl[2] = '{s0: 4095, s1: 4095, vol: 7,  e0: 2047, e1: 2047};
    tbl[3] = '{s0: 4095, s1: 4095, vol: 0,  e0: 255,  e1: 255};
    tbl[4] = '{s0: 1000, s1: 3000, vol: 3,  e0: 250,  e1: 750};

    rst = 1'b1;
    en  = 1'b0;
    bus.sample_i     = '0;
    bus.sample_tgl_i = 1'b0;
    bus.vol_i        = 4'd15;
    repeat (3) @(negedge clk);
    check("rst_state", int'(st), 0);
    check("rst_sd", int'(sd), 0);
    check("rst_pdm", int'(pdm), 0);
    check("rst_ramp", int'(dut.r_ramp), 0);
    rst = 1'b0;

    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (pdm != '0 || sd || st != 2'd0 || bus.sample_stb_o) viol++;
    end
    check("idle_off", viol, 0);
    check("idle_no_stb", stb_cnt, 0);

    send(2048, 2048, 15);
    check("capture_in_off_stb", stb_cnt, 1);
    check("capture_in_off_hold", int'(dut.r_hold_p0[0]), 2048);

    en = 1'b1;
    @(negedge clk);
    n = 0;
    while (st == 2'd1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("ramp_up_len", n, 256 * STEP_CYC);
    check("run_state", int'(st), 2);
    check("run_ramp", int'(dut.r_ramp), 256);
    check("run_sd", int'(sd), 1);

    for (int i = 0; i < 5; i++) begin
      prev = stb_cnt;
      send(tbl[i].s0, tbl[i].s1, tbl[i].vol);
      check($sformatf("tbl%0d_stb", i), stb_cnt - prev, 1);
      measure(n0, n1);
      check($sformatf("tbl%0d_ch0", i), n0, tbl[i].e0);
      check($sformatf("tbl%0d_ch1", i), n1, tbl[i].e1);
    end

    for (int i = 0; i < 6; i++) begin
      s0 = int'($urandom_range(0, 4095));
      s1 = int'($urandom_range(0, 4095));
      v  = int'($urandom_range(0, 15));
      send(s0, s1, v);
      measure(n0, n1);
      check($sformatf("rnd%0d_ch0 s=%0d v=%0d", i, s0, v), n0, ref_scale(s0, v));
      check($sformatf("rnd%0d_ch1 s=%0d v=%0d", i, s1, v), n1, ref_scale(s1, v));
    end

    send(2048, 1024, 15);
    en = 1'b0;
    @(negedge clk);
    n = 0;
    while (st == 2'd3 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check_rng("ramp_down_full_len", n, 256 * STEP_CYC - 4, 256 * STEP_CYC + 1);
    check("off_after_down", int'(st), 0);

    en = 1'b1;
    wait_ramp(100, 600, "reach_100");
    en = 1'b0;
    @(negedge clk);
    check("down_state", int'(st), 3);
    check("down_no_jump", int'(dut.r_ramp), 100);
    n = 1;
    prev_sd = int'(sd);
    @(negedge clk);
    while (st == 2'd3 && n < 1000) begin
      n++;
      prev_sd = int'(sd);
      @(negedge clk);
    end
    check_rng("down_from_100_len", n, 100 * STEP_CYC - 4, 100 * STEP_CYC + 4);
    check("off_entry_state", int'(st), 0);
    check("off_entry_sd", int'(sd), 0);
    check("sd_before_off", prev_sd, 1);
    check("off_pdm", int'(pdm), 0);

    en = 1'b1;
    wait_ramp(100, 600, "reach_100_again");
    en = 1'b0;
    wait_ramp(50, 300, "reach_50_down");
    en = 1'b1;
    @(negedge clk);
    check("resume_up_state", int'(st), 1);
    check("resume_up_ramp", int'(dut.r_ramp), 50);
    wait_ramp(51, STEP_CYC + 2, "resume_up_step");
    en = 1'b0;
    wait_ramp(50, STEP_CYC + 2, "down_to_50");
    check("down_at_50_state", int'(st), 3);

    rst = 1'b1;
    @(negedge clk);
    check("midramp_rst_state", int'(st), 0);
    check("midramp_rst_sd", int'(sd), 0);
    check("midramp_rst_pdm", int'(pdm), 0);
    check("midramp_rst_ramp", int'(dut.r_ramp), 0);
    rst = 1'b0;
    bus.sample_tgl_i = 1'b0;
    repeat (4) @(negedge clk);

    prev = stb_cnt;
    bus.sample_i     = {W'(222), W'(111)};
    bus.sample_tgl_i = ~bus.sample_tgl_i;
    repeat (2) @(negedge clk);
    bus.sample_i     = {W'(1234), W'(3333)};
    bus.sample_tgl_i = ~bus.sample_tgl_i;
    repeat (10) @(negedge clk);
    check_rng("double_tgl_stb", stb_cnt - prev, 1, 2);
    check("double_tgl_hold0", int'(dut.r_hold_p0[0]), 3333);
    check("double_tgl_hold1", int'(dut.r_hold_p0[1]), 1234);
    check("double_tgl_off_state", int'(st), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
